// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side and result signals of one ultrasonic ranger channel.
// The ranger uses the master modport; the consumer (or bench) uses slave.
interface ultrasonic_ranger_if;
    logic        echo;
    logic        trig;
    logic [12:0] distance;
    logic [6:0]  y_pos;
    logic        valid;
    logic        timeout;
    logic [2:0]  dbg_state;

    modport master (
        input  echo,
        output trig, distance, y_pos, valid, timeout, dbg_state
    );

    modport slave (
        output echo,
        input  trig, distance, y_pos, valid, timeout, dbg_state
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo-width timing, distance and clamped paddle Y.
// valid/timeout are single-cycle pulses with no backpressure; distance/y_pos hold until the next valid.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES     = 500,
    parameter int PERIOD_CYCLES   = 3000000,
    parameter int TIMEOUT_CYCLES  = 1500000,
    parameter int CYCLES_PER_UNIT = 2900,
    parameter int Y_MAX           = 88
) (
    input  logic                clock,
    input  logic                reset_n,
    ultrasonic_ranger_if.master bus
);
    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int SW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [12:0] UNIT_MAX = 13'h1FFF;
    localparam logic [12:0] Y_MAX13  = 13'(Y_MAX);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1, r_sync2, r_echo_d;
    logic        r_trig;
    logic [CW-1:0] r_trig_cnt;
    logic [PW-1:0] r_period;
    logic [TW-1:0] r_to_cnt;
    logic [SW-1:0] r_sub;
    logic [12:0] r_unit;
    logic [12:0] r_distance;
    logic [6:0]  r_y;
    logic        r_valid, r_timeout;

    logic        w_rise, w_fall, w_to_hit, w_trig_done, w_period_end;
    logic        w_count, w_sub_wrap, w_take, w_abandon;
    logic [SW-1:0] w_sub_next;
    logic [12:0] w_unit_next;

    assign w_rise       = r_sync2 & ~r_echo_d;
    assign w_fall       = ~r_sync2 & r_echo_d;
    assign w_to_hit     = (r_to_cnt == TW'(TIMEOUT_CYCLES));
    assign w_trig_done  = (r_trig_cnt == CW'(TRIG_CYCLES - 1));
    assign w_period_end = (r_period >= PW'(PERIOD_CYCLES - 1));

    // Width is counted on the delayed copy so the rise cycle and the fall cycle
    // are both included, making W equal to the number of echo_s-high cycles.
    assign w_count     = (r_state == S_MEASURE) && r_echo_d;
    assign w_sub_wrap  = (r_sub == SW'(CYCLES_PER_UNIT - 1));
    assign w_sub_next  = !w_count ? r_sub : (w_sub_wrap ? '0 : r_sub + SW'(1));
    assign w_unit_next = (w_count && w_sub_wrap && r_unit != UNIT_MAX) ? r_unit + 13'd1 : r_unit;

    // A falling edge beats a timeout landing in the same cycle.
    assign w_take    = (r_state == S_MEASURE) && w_fall;
    assign w_abandon = ((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) && w_to_hit && !w_take;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = S_TRIG;
            S_TRIG:      if (w_trig_done) w_next = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (w_to_hit)    w_next = S_HOLD;
                else if (w_rise) w_next = S_MEASURE;
            end
            S_MEASURE:   if (w_fall || w_to_hit) w_next = S_HOLD;
            S_HOLD:      if (w_period_end) w_next = S_TRIG;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_echo_d   <= 1'b0;
            r_trig     <= 1'b0;
            r_trig_cnt <= '0;
            r_period   <= '0;
            r_to_cnt   <= '0;
            r_sub      <= '0;
            r_unit     <= '0;
            r_distance <= '0;
            r_y        <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_sync1    <= bus.echo;
            r_sync2    <= r_sync1;
            r_echo_d   <= r_sync2;
            r_trig     <= (r_state == S_TRIG);
            r_trig_cnt <= (r_state == S_TRIG && w_next == S_TRIG) ? r_trig_cnt + CW'(1) : '0;
            r_period   <= (w_next == S_TRIG && r_state != S_TRIG) ? '0 : r_period + PW'(1);

            if (w_next == S_WAIT_RISE && r_state != S_WAIT_RISE)
                r_to_cnt <= '0;
            else if (r_state == S_WAIT_RISE || r_state == S_MEASURE)
                r_to_cnt <= r_to_cnt + TW'(1);

            if (w_next == S_MEASURE && r_state != S_MEASURE) begin
                r_sub  <= '0;
                r_unit <= '0;
            end else begin
                r_sub  <= w_sub_next;
                r_unit <= w_unit_next;
            end

            r_valid   <= w_take;
            r_timeout <= w_abandon;
            if (w_take) begin
                r_distance <= w_unit_next;
                r_y        <= (w_unit_next > Y_MAX13) ? Y_MAX13[6:0] : w_unit_next[6:0];
            end
        end
    end

    assign bus.trig      = r_trig;
    assign bus.distance  = r_distance;
    assign bus.y_pos     = r_y;
    assign bus.valid     = r_valid;
    assign bus.timeout   = r_timeout;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: expected result pulses are queued by the
// stimulus and checked by an independent monitor on every valid/timeout pulse.
module tb_ultrasonic_ranger;
    localparam int TRIG = 4;
    localparam int PER  = 2000;
    localparam int TO   = 1500;
    localparam int CPU  = 10;
    localparam int YMAX = 88;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   first_rise;
    logic [21:0] exp_q[$];
    logic [21:0] mon_exp;

    ultrasonic_ranger_if bus();

    ultrasonic_ranger #(
        .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO),
        .CYCLES_PER_UNIT(CPU), .Y_MAX(YMAX)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired, expected event did not occur (t=%0t)", name, $time);
    endtask

    // Word layout: {valid, timeout, distance, y_pos}
    task automatic expect_pulse(input logic kind, input int d, input int y);
        exp_q.push_back({kind, ~kind, 13'(d), 7'(y)});
    endtask

    task automatic wait_trig_rise();
        int k = 0;
        while (bus.trig !== 1'b1 && k < 2 * PER) begin
            @(negedge clock);
            k++;
        end
        if (bus.trig !== 1'b1) bound_fail("trig_rise");
    endtask

    task automatic wait_trig_fall();
        int k = 0;
        wait_trig_rise();
        while (bus.trig === 1'b1 && k < 4 * TRIG) begin
            @(negedge clock);
            k++;
        end
        if (bus.trig !== 1'b0) bound_fail("trig_fall");
    endtask

    task automatic pulse_echo(input int delay, input int width);
        repeat (delay) @(negedge clock);
        bus.echo = 1'b1;
        repeat (width) @(negedge clock);
        bus.echo = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_trig"},     32'(bus.trig),      32'd0);
        check({tag, "_distance"}, 32'(bus.distance),  32'd0);
        check({tag, "_y_pos"},    32'(bus.y_pos),     32'd0);
        check({tag, "_valid"},    32'(bus.valid),     32'd0);
        check({tag, "_timeout"},  32'(bus.timeout),   32'd0);
        check({tag, "_state"},    32'(bus.dbg_state), 32'd0);
    endtask

    // Called at the negedge where reset_n was just released.
    task automatic check_trig_start(input string tag, output int rise_cyc);
        @(negedge clock);
        check({tag, "_trig_edge1"}, 32'(bus.trig), 32'd0);
        @(negedge clock);
        check({tag, "_trig_edge2"}, 32'(bus.trig), 32'd1);
        rise_cyc = cyc;
        repeat (TRIG - 1) @(negedge clock);
        check({tag, "_trig_last"}, 32'(bus.trig), 32'd1);
        @(negedge clock);
        check({tag, "_trig_end"}, 32'(bus.trig), 32'd0);
    endtask

    always @(negedge clock) begin
        if (bus.valid || bus.timeout) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got valid=%0b timeout=%0b distance=%0d, expected no pulse (t=%0t)",
                         bus.valid, bus.timeout, bus.distance, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_pulse", 32'({bus.valid, bus.timeout, bus.distance, bus.y_pos}), 32'(mon_exp));
            end
        end
    end

    initial begin
        bus.echo = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");

        // Power-up with no echo: trigger timing, timeout latency, period spacing
        reset_n = 1'b1;
        check_trig_start("pwr", first_rise);
        expect_pulse(1'b0, 0, 0);
        n = 0;
        while (!bus.timeout && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TO));
        check("distance_after_timeout", 32'(bus.distance), 32'd0);
        wait_trig_rise();
        check("trigger_period", 32'(cyc - first_rise), 32'(PER));

        wait_trig_fall();
        expect_pulse(1'b1, 25, 25);
        pulse_echo(50, 250);

        wait_trig_fall();
        expect_pulse(1'b1, 100, 88);
        pulse_echo(50, 1000);

        wait_trig_fall();
        expect_pulse(1'b1, 5, 5);
        pulse_echo(50, 59);

        // Echo already high when WAIT_RISE starts
        wait_trig_rise();
        bus.echo = 1'b1;
        wait_trig_fall();
        repeat (20) @(negedge clock);
        bus.echo = 1'b0;
        expect_pulse(1'b1, 12, 12);
        pulse_echo(30, 120);

        // Echo that never falls
        wait_trig_fall();
        expect_pulse(1'b0, 12, 12);
        repeat (50) @(negedge clock);
        bus.echo = 1'b1;
        repeat (1600) @(negedge clock);
        bus.echo = 1'b0;

        wait_trig_fall();
        expect_pulse(1'b1, 30, 30);
        pulse_echo(50, 300);

        // Reset in the middle of a measurement
        wait_trig_fall();
        repeat (50) @(negedge clock);
        bus.echo = 1'b1;
        repeat (100) @(negedge clock);
        reset_n  = 1'b0;
        bus.echo = 1'b0;
        @(negedge clock);
        check_outputs_zero("mid_reset");
        reset_n = 1'b1;
        check_trig_start("restart", first_rise);
        expect_pulse(1'b0, 0, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
